// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared port-select widths, port index constants and the {port,data} record type
package cpu_io_pkg;
  localparam int PORT_SEL_W = 2;
  localparam int NUM_OUT_PORTS = 4;
  localparam int REC_DATA_W = 8;
  localparam logic [PORT_SEL_W-1:0] PORT0 = 2'd0;
  localparam logic [PORT_SEL_W-1:0] PORT1 = 2'd1;
  localparam logic [PORT_SEL_W-1:0] PORT2 = 2'd2;
  localparam logic [PORT_SEL_W-1:0] PORT3 = 2'd3;
  typedef struct packed {
    logic [PORT_SEL_W-1:0] port;
    logic [REC_DATA_W-1:0] data;
  } io_rec_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-storage FIFO; head shown combinationally, zero when empty
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  // a pop on the same edge frees the slot the push needs
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/cpu_out_port_buffer.sv
// cpu_out_port_buffer: four CPU output port registers plus a {port,data} record queue with sticky overflow.
// Define CPU_OUT_CHANGE_ONLY_EN to enqueue only writes that change the port value.
module cpu_out_port_buffer
  import cpu_io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [PORT_SEL_W-1:0]   wr_port,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       out_p0,
  output logic [DATA_W-1:0]       out_p1,
  output logic [DATA_W-1:0]       out_p2,
  output logic [DATA_W-1:0]       out_p3,
  output logic                    rd_valid,
  output logic [PORT_SEL_W-1:0]   rd_port,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    rd_ready,
  output logic                    fifo_full,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    ovf,
  input  logic                    ovf_clr
);
  logic [DATA_W-1:0] p [NUM_OUT_PORTS];
  logic [PORT_SEL_W+DATA_W-1:0] head;
  logic want, pop, empty;
`ifdef CPU_OUT_CHANGE_ONLY_EN
  assign want = wr_en & (wr_data != p[wr_port]);
`else
  assign want = wr_en;
`endif
  assign pop = rd_valid & rd_ready;
  assign rd_valid = ~empty;
  assign {rd_port, rd_data} = head;
  assign out_p0 = p[PORT0];
  assign out_p1 = p[PORT1];
  assign out_p2 = p[PORT2];
  assign out_p3 = p[PORT3];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) p[i] <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr_en) p[wr_port] <= wr_data;
      if (want & fifo_full & ~pop) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end
  sync_fifo #(.WIDTH(PORT_SEL_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (want),
    .pop   (pop),
    .din   ({wr_port, wr_data}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (empty)
  );
endmodule
